arp_sequencer: RTL and testbench
================================

ARP_SEQUENCER -- requirements
Module: arp_sequencer

Interface
REQ-001 Parameter DWELL_CYCLES, default 25_000_000, clock cycles each arpeggio note is held (0.25 s at 100 MHz).
REQ-002 Parameter BASE_DIV, default 746, base sample-period offset added to SW.
REQ-003 CLK100MHZ  input  1  sole clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 SW  input  8  pitch select; base divisor = BASE_DIV + SW.
REQ-006 arp_toggle  input  1  single-cycle pulse from debouncer; toggles arpeggio enable.
REQ-007 addra  output  8  sine-table BRAM read address.
REQ-008 addr_stb  output  1  one-cycle pulse, high in the cycle addra takes a new value.
REQ-009 note  output  2  current note state, drives LED[1:0].
REQ-010 arp_en  output  1  arpeggio enable state.

Function
REQ-011 SW shall be registered through two flip-flop stages before use; pitch changes take effect 2 cycles after SW changes.
REQ-012 f_base shall be 10 bits wide: BASE_DIV + SW_sync, range 746..1001, no truncation.
REQ-013 Note divisor shall be (f_base * M) >> 4, 10 bits, with M = 16, 13, 11, 8 for note 0, 1, 2, 3 (root, ~third, ~fifth, octave).
REQ-014 Sample counter (10 bits) shall increment every cycle; when it equals divisor-1 it shall clear to 0, addra shall increment by 1, and addr_stb shall pulse in the following cycle together with the new addra.
REQ-015 addra shall wrap from 255 to 0 with no gap cycle.
REQ-016 Divisor shall be latched into an active-divisor register only when the sample counter clears; mid-period pitch/note changes shall not shorten or stretch the current period.
REQ-017 If the counter is ever >= active divisor-1 (defensive), it shall clear as at terminal count.
REQ-018 Note FSM states: N0, N1, N2, N3 (note = 0..3).
REQ-019 arp_en=0: FSM held in N0, dwell counter held at 0.
REQ-020 arp_en=1: dwell counter (27 bits) increments each cycle; at DWELL_CYCLES-1 it clears and FSM advances N0->N1->N2->N3->N0.
REQ-021 arp_toggle=1 shall invert arp_en next cycle; on disable, note shall be N0 and dwell counter 0 on that same next cycle; on enable, sequence starts at N0 with dwell counter 0.
REQ-022 arp_toggle coincident with dwell terminal count: toggle takes priority, no note advance.
REQ-023 addra/sample counter shall free-run regardless of arp_en; only the divisor changes.

Reset
REQ-024 On rst=1 at a clock edge: addra=0, addr_stb=0, note=0 (N0), arp_en=0, sample counter=0, dwell counter=0, SW synchronisers=0, active divisor=BASE_DIV.
REQ-025 rst shall override arp_toggle and all terminal-count events in the same cycle; mid-period reset discards the partial sample period.

Structure
REQ-026 Shared package arp_pkg shall hold note-state encoding, ratio multipliers M (16,13,11,8) and default BASE_DIV / DWELL_CYCLES.
REQ-027 One sub-module, note_divider, shall compute the divisor combinationally from f_base and note via shift-add only (no dividers or DSP multipliers).
REQ-028 The top shall connect addra to BRAM addra and note to LED[1:0]; PWM path is unchanged.

Verification
REQ-029 rst, SW=0, arp off -> addr_stb every 746 cycles; addra 0..255 then 0; full period 190_976 cycles.
REQ-030 SW=255, arp on, DWELL_CYCLES=2000 override -> note 0,1,2,3,0 every 2000 cycles; strobe spacing 1001, 813, 688, 500 cycles.
REQ-031 SW changes 0->255 mid-period -> current period completes at 746, next period 1001 (after 2-cycle sync).
REQ-032 arp_toggle pulse in N2, then again -> note=0 next cycle on disable; re-enable restarts at N0 with full dwell.
REQ-033 arp_toggle coincident with dwell terminal count in N1 -> arp_en=0, note=0, no transition to N2.
REQ-034 rst asserted with addra=137, note=N3, arp_en=1 -> all outputs at reset values next cycle; first strobe 746 cycles after rst release with SW=0.

Source files
------------

// File: rtl/arp_pkg.sv
// Shared definitions for the arpeggio sequencer.
// Holds the note-state encoding, the interval ratio multipliers applied to the
// base sample period, default timing parameters, and small helper functions.
package arp_pkg;

  typedef enum logic [1:0] {
    N0 = 2'd0,   // root
    N1 = 2'd1,   // ~third
    N2 = 2'd2,   // ~fifth
    N3 = 2'd3    // octave
  } note_t;

  localparam int unsigned DEF_BASE_DIV     = 746;
  localparam int unsigned DEF_DWELL_CYCLES = 25_000_000;

  // Sample-period multipliers in sixteenths; indexed by note number.
  localparam logic [4:0] RATIO_M [4] = '{5'd16, 5'd13, 5'd11, 5'd8};

  function automatic note_t next_note(input note_t n);
    return note_t'(n + 2'd1);
  endfunction

  // Multiply by a small constant using only shifts and adds; with a constant
  // m the loop collapses to a fixed adder tree.
  function automatic logic [13:0] shift_add(input logic [9:0] f, input logic [4:0] m);
    logic [13:0] acc;
    acc = '0;
    for (int i = 0; i < 5; i++) begin
      if (m[i]) acc = acc + ({4'b0000, f} << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/arp_sequencer_note_divider.sv
// note_divider: combinational sample-period divisor for the current note.
// Ports:
//   f_base  in  10  base divisor (BASE_DIV + synchronised SW)
//   note    in   2  current note state
//   divisor out 10  (f_base * M[note]) >> 4
module note_divider
  import arp_pkg::*;
(
  input  logic [9:0] f_base,
  input  note_t      note,
  output logic [9:0] divisor
);

  logic [13:0] prod;

  always_comb begin
    prod = '0;
    case (note)
      N0:      prod = shift_add(f_base, RATIO_M[0]);
      N1:      prod = shift_add(f_base, RATIO_M[1]);
      N2:      prod = shift_add(f_base, RATIO_M[2]);
      default: prod = shift_add(f_base, RATIO_M[3]);
    endcase
  end

  // Largest product is 1001*16, which fits 14 bits; >>4 always fits 10 bits.
  assign divisor = 10'(prod >> 4);

endmodule

// File: rtl/arp_sequencer.sv
// arp_sequencer: steps a sine-table read address at a pitch set by SW, with an
// optional arpeggio that cycles root / third / fifth / octave.
// Ports:
//   CLK100MHZ  in   1  clock
//   rst        in   1  synchronous active-high reset
//   SW         in   8  pitch select (asynchronous, synchronised here)
//   arp_toggle in   1  one-cycle pulse, toggles arpeggio enable
//   addra      out  8  sine-table BRAM read address
//   addr_stb   out  1  high in the cycle addra takes a new value
//   note       out  2  current note (drives LED[1:0])
//   arp_en     out  1  arpeggio enable
//
// state | meaning
// N0    | root, also the idle state while the arpeggio is off
// N1    | ~major third (M=13)
// N2    | ~fifth (M=11)
// N3    | octave (M=8)
module arp_sequencer
  import arp_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = DEF_DWELL_CYCLES,
  parameter int unsigned BASE_DIV     = DEF_BASE_DIV
) (
  input  logic       CLK100MHZ,
  input  logic       rst,
  input  logic [7:0] SW,
  input  logic       arp_toggle,
  output logic [7:0] addra,
  output logic       addr_stb,
  output logic [1:0] note,
  output logic       arp_en
);

  localparam logic [9:0]  BASE_DIV_W = 10'(BASE_DIV);
  localparam logic [26:0] DWELL_LAST = 27'(DWELL_CYCLES - 1);

  logic [7:0]  sw_s1, sw_s2;
  logic [9:0]  f_base, divisor, active_div, sample_cnt;
  logic [26:0] dwell_cnt;
  note_t       note_q;
  logic        sample_tc, dwell_tc;

  assign f_base = BASE_DIV_W + {2'b00, sw_s2};

  note_divider u_note_divider (
    .f_base  (f_base),
    .note    (note_q),
    .divisor (divisor)
  );

  // >= rather than == so a corrupted counter can never run away past the period.
  assign sample_tc = (sample_cnt >= active_div - 10'd1);
  assign dwell_tc  = (dwell_cnt == DWELL_LAST);
  assign note      = note_q;

  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      sw_s1      <= '0;
      sw_s2      <= '0;
      sample_cnt <= '0;
      active_div <= BASE_DIV_W;
      addra      <= '0;
      addr_stb   <= 1'b0;
      dwell_cnt  <= '0;
      note_q     <= N0;
      arp_en     <= 1'b0;
    end else begin
      sw_s1    <= SW;
      sw_s2    <= sw_s1;
      addr_stb <= 1'b0;

      // Divisor is only sampled at a period boundary so pitch and note changes
      // never distort the period already in progress.
      if (sample_tc) begin
        sample_cnt <= '0;
        active_div <= divisor;
        addra      <= addra + 8'd1;
        addr_stb   <= 1'b1;
      end else begin
        sample_cnt <= sample_cnt + 10'd1;
      end

      // Toggle wins over a coincident dwell terminal count.
      if (arp_toggle) begin
        arp_en    <= ~arp_en;
        note_q    <= N0;
        dwell_cnt <= '0;
      end else if (!arp_en) begin
        note_q    <= N0;
        dwell_cnt <= '0;
      end else if (dwell_tc) begin
        note_q    <= next_note(note_q);
        dwell_cnt <= '0;
      end else begin
        dwell_cnt <= dwell_cnt + 27'd1;
      end
    end
  end

endmodule

// File: tb/tb_arp_sequencer.sv
// Self-checking bench for arp_sequencer. A reference model predicts strobe
// times from the period rules (next strobe = last strobe + divisor chosen at
// that strobe) and the note from elapsed time since enable; a separate monitor
// compares DUT outputs against queued expectations.
module tb_arp_sequencer;

  localparam int DW   = 2000;
  localparam int BASE = 746;

  logic       CLK100MHZ = 1'b1;
  logic       rst = 1'b1;
  logic [7:0] SW = '0;
  logic       arp_toggle = 1'b0;
  logic [7:0] addra;
  logic       addr_stb;
  logic [1:0] note;
  logic       arp_en;

  arp_sequencer #(.DWELL_CYCLES(DW), .BASE_DIV(BASE)) dut (
    .CLK100MHZ  (CLK100MHZ),
    .rst        (rst),
    .SW         (SW),
    .arp_toggle (arp_toggle),
    .addra      (addra),
    .addr_stb   (addr_stb),
    .note       (note),
    .arp_en     (arp_en)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  typedef struct {
    int         at;
    logic [7:0] addr;
  } stb_t;

  typedef struct {
    logic [7:0] addr;
    logic [1:0] note;
    logic       en;
  } st_t;

  stb_t sq[$];
  st_t  stq[$];

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         k = 0;
  int         te = 0;
  int         next_clr = 0;
  int         note_m = 0;
  bit         en_m = 1'b0;
  logic [7:0] addr_m = '0;
  logic [7:0] sw_d1 = '0;
  logic [7:0] sw_d2 = '0;
  logic [7:0] cur_sw = '0;
  int         mult[4] = '{16, 13, 11, 8};
  int         m = 0;

  task automatic step(input bit r, input logic [7:0] sw, input bit tog);
    int div;
    stb_t s;
    st_t  e;
    @(negedge CLK100MHZ);
    k++;
    rst = r;
    SW = sw;
    arp_toggle = tog;
    if (r) begin
      addr_m = '0;
      en_m = 1'b0;
      note_m = 0;
      sw_d1 = '0;
      sw_d2 = '0;
      next_clr = k + BASE;
    end else begin
      if (k == next_clr) begin
        div = ((BASE + int'(sw_d2)) * mult[note_m]) / 16;
        addr_m = addr_m + 8'd1;
        next_clr = k + div;
        s.at = k;
        s.addr = addr_m;
        sq.push_back(s);
      end
      if (tog) begin
        en_m = !en_m;
        note_m = 0;
        if (en_m) te = k;
      end else if (en_m) begin
        note_m = ((k - te) / DW) % 4;
      end else begin
        note_m = 0;
      end
      sw_d2 = sw_d1;
      sw_d1 = sw;
    end
    e.addr = addr_m;
    e.note = 2'(note_m);
    e.en = en_m;
    stq.push_back(e);
  endtask

  task automatic run(input int n);
    repeat (n) step(1'b0, cur_sw, 1'b0);
  endtask

  task automatic pulse();
    step(1'b0, cur_sw, 1'b1);
  endtask

  // Monitor: one state record per cycle, strobe records only when due.
  initial begin
    st_t  e;
    stb_t s;
    forever begin
      @(posedge CLK100MHZ);
      m++;
      #1;
      checks++;
      if (stq.size() == 0) begin
        errors++;
        $display("FAIL state_queue cycle %0d: no expectation queued", m);
      end else begin
        e = stq.pop_front();
        if (addra !== e.addr || note !== e.note || arp_en !== e.en) begin
          errors++;
          $display("FAIL state cycle %0d: got addra=%0d note=%0d arp_en=%0b, want addra=%0d note=%0d arp_en=%0b",
                   m, addra, note, arp_en, e.addr, e.note, e.en);
        end
      end
      if (addr_stb === 1'b1) begin
        checks++;
        if (sq.size() == 0 || sq[0].at != m) begin
          errors++;
          $display("FAIL strobe_unexpected cycle %0d: got addr_stb=1 addra=%0d, want no strobe (next due %0d)",
                   m, addra, (sq.size() == 0) ? -1 : sq[0].at);
        end else begin
          s = sq.pop_front();
          if (addra !== s.addr) begin
            errors++;
            $display("FAIL strobe_addr cycle %0d: got addra=%0d, want %0d", m, addra, s.addr);
          end
        end
      end else if (sq.size() > 0 && sq[0].at == m) begin
        checks++;
        errors++;
        s = sq.pop_front();
        $display("FAIL strobe_missed cycle %0d: got addr_stb=%b, want 1 with addra=%0d", m, addr_stb, s.addr);
      end
    end
  end

  initial begin
    // Reset, SW=0, arpeggio off: strobes every 746 cycles
    step(1'b1, 8'd0, 1'b0);
    step(1'b1, 8'd0, 1'b0);
    cur_sw = 8'd0;
    run(2000);
    // SW 0->255 mid-period: current period keeps 746, next uses 1001
    run(300);
    cur_sw = 8'd255;
    run(3000);
    // Arpeggio on at SW=255: notes 0..3 with spacings 1001/813/688/500
    pulse();
    run(9000);
    // Disable while in N2, then re-enable
    run(te + 2 * DW + 500 - k - 1);
    pulse();
    run(300);
    pulse();
    run(2500);
    // Toggle coincident with dwell terminal count in N1
    run(te + 2 * DW - k - 1);
    pulse();
    run(2000);
    // Reset in N3 with a toggle on the same edge; reset must win
    pulse();
    run(3 * DW + 100);
    step(1'b1, cur_sw, 1'b1);
    cur_sw = 8'd0;
    run(1500);
    // Randomised pitch changes, toggles and occasional resets
    for (int i = 0; i < 40000; i++) begin
      bit r, t;
      r = ($urandom_range(0, 19999) == 0);
      t = ($urandom_range(0, 2999) == 0);
      if ($urandom_range(0, 499) == 0) cur_sw = 8'($urandom);
      step(r, cur_sw, t);
    end
    run(5);
    @(posedge CLK100MHZ);
    #2;
    checks++;
    if (sq.size() != 0 || stq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d strobe and %0d state expectations left, want 0 and 0", sq.size(), stq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
